// File: rtl/control_botones_pkg.sv
// -----------------------------------------------------------------------------
// control_botones_pkg
// Shared definitions for the button front end of the clock/calendar setup path:
// field codes driven on contadoresH, the step FSM state encoding, default
// timing parameters and the wrap-around helper for the field selector.
// -----------------------------------------------------------------------------
package control_botones_pkg;

  // Default timing at 100 MHz
  localparam int DEF_DEB_CYCLES = 1000000;   // 10 ms debounce
  localparam int DEF_REP_DELAY  = 50000000;  // 0.5 s before auto-repeat
  localparam int DEF_REP_PERIOD = 25000000;  // ~4 Hz repeat rate
  localparam int DEF_NUM_FIELDS = 5;

  // Field codes seen by the downstream counters
  localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
  localparam logic [3:0] CAMPO_HORA    = 4'd1;
  localparam logic [3:0] CAMPO_MIN     = 4'd2;
  localparam logic [3:0] CAMPO_DIA     = 4'd3;
  localparam logic [3:0] CAMPO_ANHO    = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BLOCK      = 2'd1,
    ST_WAIT_FIRST = 2'd2,
    ST_REPEAT     = 2'd3
  } step_state_t;

  // Move one field forward or backward, wrapping inside 1..last
  function automatic logic [3:0] step_field(input logic [3:0] f,
                                            input logic [3:0] last,
                                            input logic       fwd);
    if (fwd) return (f >= last) ? CAMPO_HORA : f + 4'd1;
    else     return (f <= CAMPO_HORA) ? last : f - 4'd1;
  endfunction

endpackage

// File: rtl/control_botones_antirrebote.sv
// -----------------------------------------------------------------------------
// antirrebote
// Two-flop synchronizer followed by a debounce counter for one raw button.
// The debounced level only flips after DEB_CYCLES consecutive synchronized
// samples disagree with it; shorter bounces are absorbed.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   raw    in   raw button, asynchronous to clk
//   level  out  debounced level
//   rise   out  one-cycle pulse the cycle after level goes 0 -> 1
// -----------------------------------------------------------------------------
module antirrebote
  import control_botones_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p1;
  logic             sync_p2;
  logic             level_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p1  <= 1'b0;
      sync_p2  <= 1'b0;
      level    <= 1'b0;
      level_p1 <= 1'b0;
      cnt      <= '0;
      rise     <= 1'b0;
    end else begin
      sync_p1 <= raw;
      sync_p2 <= sync_p1;
      // Any sample agreeing with the current level restarts the stability count
      if (sync_p2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      level_p1 <= level;
      rise     <= level & ~level_p1;
    end
  end

endmodule

// File: rtl/control_botones.sv
// -----------------------------------------------------------------------------
// control_botones
// Button conditioner for the clock/calendar configuration path. Debounces the
// four buttons, keeps track of the field being edited (contadoresH) and issues
// one-cycle Arriba/Abajo step pulses for the per-field counters.
//
// Build option: define AUTO_REPEAT_EN to add hold-to-repeat (WAIT_FIRST and
// REPEAT states plus the repeat counter). Without it each debounced press gives
// exactly one step pulse.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   config_en    in   configuration mode enable (level)
//   btn_up       in   raw button, increment
//   btn_down     in   raw button, decrement
//   btn_left     in   raw button, previous field
//   btn_right    in   raw button, next field
//   contadoresH  out  selected field code (0 = none, 1..NUM_FIELDS)
//   Arriba       out  increment pulse, one clk wide
//   Abajo        out  decrement pulse, one clk wide
// -----------------------------------------------------------------------------
module control_botones
  import control_botones_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int REP_DELAY  = DEF_REP_DELAY,
  parameter int REP_PERIOD = DEF_REP_PERIOD,
  parameter int NUM_FIELDS = DEF_NUM_FIELDS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       config_en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] contadoresH,
  output logic       Arriba,
  output logic       Abajo
);

  if (DEB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1 ||
      NUM_FIELDS < 1 || NUM_FIELDS > 15) begin : g_bad_params
    $error("control_botones: illegal parameter set");
  end

  localparam logic [3:0] LAST_FIELD = 4'(NUM_FIELDS);

  logic lvl_up, lvl_down, lvl_left, lvl_right;
  logic rise_up, rise_down, rise_left, rise_right;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(lvl_up), .rise(rise_up));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(lvl_down), .rise(rise_down));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .reset(reset), .raw(btn_left), .level(lvl_left), .rise(rise_left));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .reset(reset), .raw(btn_right), .level(lvl_right), .rise(rise_right));

  // Field selection reacts to press events only; the held levels of
  // left/right carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{lvl_left, lvl_right};

  logic       cfg_p1, cfg_p2;
  logic [3:0] field, field_next;
  logic       field_chg;
  logic       up_p, down_p;

  always_comb begin
    field_next = field;
    if (!config_en) begin
      field_next = CAMPO_NINGUNO;
    end else if (cfg_p1 && !cfg_p2) begin
      field_next = CAMPO_HORA;
    end else if (field != CAMPO_NINGUNO && (rise_right ^ rise_left)) begin
      field_next = step_field(field, LAST_FIELD, rise_right);
    end
  end

  assign field_chg   = (field_next != field);
  assign contadoresH = field;

  step_state_t state, state_next;

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LOAD  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LOAD = REP_W'(REP_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt, rep_cnt_next;
  logic             dir, dir_next;     // latched direction: 1 = down
  logic             held, other;

  assign held  = dir ? lvl_down : lvl_up;
  assign other = dir ? lvl_up   : lvl_down;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      rep_cnt <= '0;
      dir     <= 1'b0;
    end else begin
      state   <= state_next;
      rep_cnt <= rep_cnt_next;
      dir     <= dir_next;
    end
  end

  always_comb begin
    state_next   = state;
    rep_cnt_next = rep_cnt;
    dir_next     = dir;
    up_p         = 1'b0;
    down_p       = 1'b0;
    if (!config_en || field_chg) begin
      state_next   = ST_IDLE;
      rep_cnt_next = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lvl_up && lvl_down) begin
            state_next = ST_BLOCK;
          end else if (rise_up || rise_down) begin
            state_next   = ST_WAIT_FIRST;
            rep_cnt_next = DELAY_LOAD;
            dir_next     = rise_down;
            up_p         = rise_up;
            down_p       = rise_down;
          end
        end
        ST_BLOCK: begin
          if (!lvl_up && !lvl_down) state_next = ST_IDLE;
        end
        ST_WAIT_FIRST, ST_REPEAT: begin
          if (other) begin
            state_next   = ST_BLOCK;
            rep_cnt_next = '0;
          end else if (!held) begin
            state_next   = ST_IDLE;
            rep_cnt_next = '0;
          end else if (rep_cnt == '0) begin
            state_next   = ST_REPEAT;
            rep_cnt_next = PERIOD_LOAD;
            up_p         = ~dir;
            down_p       = dir;
          end else begin
            rep_cnt_next = rep_cnt - 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Single pulse per press: staying in IDLE while held is enough, since a
  // new pulse needs a new rise event.
  always_comb begin
    state_next = state;
    up_p       = 1'b0;
    down_p     = 1'b0;
    if (!config_en || field_chg) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lvl_up && lvl_down) begin
            state_next = ST_BLOCK;
          end else begin
            up_p   = rise_up;
            down_p = rise_down;
          end
        end
        ST_BLOCK: begin
          if (!lvl_up && !lvl_down) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_p1 <= 1'b0;
      cfg_p2 <= 1'b0;
      field  <= CAMPO_NINGUNO;
      Arriba <= 1'b0;
      Abajo  <= 1'b0;
    end else begin
      cfg_p1 <= config_en;
      cfg_p2 <= cfg_p1;
      field  <= field_next;
      Arriba <= up_p   & config_en & (field != CAMPO_NINGUNO);
      Abajo  <= down_p & config_en & (field != CAMPO_NINGUNO);
    end
  end

endmodule

// File: tb/tb_control_botones.sv
module tb_control_botones;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int NF  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       config_en = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] contadoresH;
  logic       Arriba, Abajo;

  always #5 clk = ~clk;

  control_botones #(
    .DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_PERIOD(RP), .NUM_FIELDS(NF)
  ) dut (
    .clk(clk), .reset(reset), .config_en(config_en),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .contadoresH(contadoresH), .Arriba(Arriba), .Abajo(Abajo)
  );

  int checks = 0;
  int errors = 0;
  int n_arr = 0;
  int n_aba = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: button index 0 up, 1 down, 2 left, 3 right
  int cyc;
  bit m_pipe0[4], m_pipe1[4], m_lvl[4], m_went[4], m_rise[4];
  int m_run[4];
  int m_field;
  bit m_cq1, m_cq2, m_arr, m_aba, m_blocked;
  int m_active;   // 0 none, 1 up held, 2 down held (auto-repeat build)
  int m_tstart;   // model cycle of the press pulse

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      m_pipe0[b] = 0; m_pipe1[b] = 0; m_lvl[b] = 0; m_went[b] = 0; m_rise[b] = 0; m_run[b] = 0;
    end
    m_field = 0; m_cq1 = 0; m_cq2 = 0; m_arr = 0; m_aba = 0;
    m_blocked = 0; m_active = 0; m_tstart = 0;
  endtask

  task automatic model_step();
    bit raw[4];
    int nf, n;
    bit up_p, dn_p, held, other, d;
    raw = '{btn_up, btn_down, btn_left, btn_right};
    nf = m_field;
    if (!config_en) nf = 0;
    else if (m_cq1 && !m_cq2) nf = 1;
    else if (m_field != 0 && (m_rise[3] ^ m_rise[2]))
      nf = m_rise[3] ? (m_field % NF) + 1 : ((m_field + NF - 2) % NF) + 1;
    up_p = 0; dn_p = 0;
    if (!config_en || nf != m_field) begin
      m_active = 0; m_blocked = 0;
    end else if (m_blocked) begin
      if (!m_lvl[0] && !m_lvl[1]) m_blocked = 0;
    end else if (m_active != 0) begin
      held  = m_lvl[m_active - 1];
      other = m_lvl[2 - m_active];
      if (other) begin m_blocked = 1; m_active = 0; end
      else if (!held) m_active = 0;
      else begin
        n = cyc - m_tstart;
        if (n >= RD && (n - RD) % RP == 0) begin
          if (m_active == 1) up_p = 1; else dn_p = 1;
        end
      end
    end else begin
      if (m_lvl[0] && m_lvl[1]) m_blocked = 1;
      else if (m_rise[0] || m_rise[1]) begin
        up_p = m_rise[0]; dn_p = m_rise[1];
`ifdef AUTO_REPEAT_EN
        m_active = m_rise[0] ? 1 : 2;
        m_tstart = cyc;
`endif
      end
    end
    m_arr = up_p && config_en && m_field != 0;
    m_aba = dn_p && config_en && m_field != 0;
    m_field = nf;
    m_cq2 = m_cq1;
    m_cq1 = config_en;
    // Debounce: level flips after DEB consecutive disagreeing samples seen
    // two clocks late; rise reported the step after the flip.
    for (int b = 0; b < 4; b++) begin
      d = m_pipe1[b];
      m_pipe1[b] = m_pipe0[b];
      m_pipe0[b] = raw[b];
      m_rise[b] = m_went[b];
      m_went[b] = 0;
      if (d != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = !m_lvl[b];
          m_run[b] = 0;
          m_went[b] = m_lvl[b];
        end
      end else m_run[b] = 0;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    chk("contadoresH", int'(contadoresH), m_field);
    chk("Arriba", int'(Arriba), int'(m_arr));
    chk("Abajo", int'(Abajo), int'(m_aba));
    chk("step_exclusive", int'(Arriba & Abajo), 0);
    if (Arriba) n_arr++;
    if (Abajo) n_aba++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_up = v;
      1: btn_down = v;
      2: btn_left = v;
      default: btn_right = v;
    endcase
  endtask

  task automatic press(input int b, input int n);
    set_btn(b, 1'b1);
    ticks(n);
    set_btn(b, 1'b0);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("reset_field", int'(contadoresH), 0);
    chk("reset_arriba", int'(Arriba), 0);
    chk("reset_abajo", int'(Abajo), 0);
  endtask

  initial begin
    int a0, b0, first, second, third, target, exp_fields[5];
    cyc = 0;
    model_reset();
    #2;
    async_reset();
    ticks(2);
    reset = 1'b1;
    ticks(2);

    // Mode entry
    config_en = 1'b1;
    tick();
    chk("mode_entry_t1", int'(contadoresH), 0);
    tick();
    chk("mode_entry_t2", int'(contadoresH), 1);
    ticks(3);

    // Field wrap
    exp_fields = '{2, 3, 4, 5, 1};
    for (int i = 0; i < 5; i++) begin
      press(3, 8);
      ticks(10);
      chk($sformatf("right_%0d", i), int'(contadoresH), exp_fields[i]);
    end
    press(2, 8);
    ticks(10);
    chk("left_wrap", int'(contadoresH), 5);
    btn_left = 1'b1; btn_right = 1'b1;
    ticks(8);
    btn_left = 1'b0; btn_right = 1'b0;
    ticks(10);
    chk("left_right_same", int'(contadoresH), 5);

    // Debounce glitches and clean press latency
    for (int g = 1; g <= 3; g++) begin
      a0 = n_arr;
      press(0, g);
      ticks(10);
      chk($sformatf("glitch_%0d", g), n_arr - a0, 0);
    end
    a0 = n_arr;
    first = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (Arriba && first < 0) first = i;
    end
    btn_up = 1'b0;
    chk("press_latency_edges", first - 1, DEB + 3);
    chk("clean_press_count", n_arr - a0, 1);
    ticks(12);

    // Long hold: auto-repeat or single pulse
    a0 = n_arr;
    first = -1; second = -1; third = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (Arriba) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
        else if (third < 0) third = i;
      end
    end
    btn_up = 1'b0;
    ticks(15);
`ifdef AUTO_REPEAT_EN
    chk("repeat_count", n_arr - a0, 6);
    chk("repeat_first_gap", second - first, RD);
    chk("repeat_period", third - second, RP);
`else
    chk("single_pulse_count", n_arr - a0, 1);
`endif

    // Conflict: down held, then up pressed
    btn_down = 1'b1;
    ticks(30);
    a0 = n_arr;
    btn_up = 1'b1;
    ticks(10);
    b0 = n_aba;
    ticks(30);
    chk("conflict_abajo_stops", n_aba - b0, 0);
    chk("conflict_no_arriba", n_arr - a0, 0);
    btn_up = 1'b0; btn_down = 1'b0;
    ticks(12);
    a0 = n_arr;
    press(0, 12);
    ticks(12);
    chk("after_conflict_press", n_arr - a0, 1);

    // Gating by config_en
    config_en = 1'b0;
    a0 = n_arr;
    btn_up = 1'b1;
    ticks(30);
    chk("gated_arriba", n_arr - a0, 0);
    chk("gated_field", int'(contadoresH), 0);
    btn_up = 1'b0;
    ticks(10);
    config_en = 1'b1;
    ticks(3);

    // Reset while a step pulse is on the output
`ifdef AUTO_REPEAT_EN
    target = 2;
`else
    target = 1;
`endif
    a0 = n_arr;
    btn_up = 1'b1;
    for (int i = 0; i < 60 && (n_arr - a0) < target; i++) tick();
    chk("reached_hold_pulse", n_arr - a0, target);
    #2;
    async_reset();
    ticks(2);
    reset = 1'b1;
    a0 = n_arr;
    ticks(14);
    chk("post_reset_pulse", n_arr - a0, 1);
    btn_up = 1'b0;
    ticks(12);

    // Randomized traffic checked against the model every cycle
    for (int s = 0; s < 150; s++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) config_en = ~config_en;
      r = $urandom_range(0, 15);
      btn_up    = r[0] && ($urandom_range(0, 1) == 1);
      btn_down  = r[1] && ($urandom_range(0, 2) == 1);
      btn_left  = r[2] && ($urandom_range(0, 3) == 1);
      btn_right = r[3] && ($urandom_range(0, 3) == 1);
      ticks($urandom_range(1, 30));
    end
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    ticks(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_botones.md
Name: control_botones

Overview:
- Front-end button conditioner for the clock/calendar configuration path.
- Synchronizes and debounces four raw push-buttons, then tracks which time/date field is being edited (contadoresH).
- Produces single-cycle Arriba/Abajo step pulses, with optional auto-repeat while held.
- Sits directly upstream of the per-field counters (hour, minute, …, year = field 4); those counters consume contadoresH, Arriba and Abajo unchanged.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable samples required to accept a new debounced level (10 ms at 100 MHz).
- REP_DELAY, 50000000: cycles from the first step pulse to the first repeat pulse while held.
- REP_PERIOD, 25000000: cycles between subsequent repeat pulses (~4 Hz).
- NUM_FIELDS, 5: number of selectable fields; legal codes are 1..NUM_FIELDS, and 0 means none.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- config_en  in  1  configuration mode enable (level).
- btn_up  in  1  raw button, active-high, asynchronous to clk.
- btn_down  in  1  raw button.
- btn_left  in  1  raw button.
- btn_right  in  1  raw button.
- contadoresH  out  4  selected field code.
- Arriba  out  1  increment pulse, one clk wide.
- Abajo  out  1  decrement pulse, one clk wide.

Behaviour:
- Reset (reset=0, asynchronous) clears all of the following immediately:
  - synchronizers and debounce counters;
  - debounced levels (all 0);
  - repeat FSM (IDLE);
  - outputs: contadoresH=0, Arriba=0, Abajo=0.
- Deasserting reset mid-press: the button is treated as newly pressed once it is debounced.
- Input path, per button:
  - 2-FF synchronizer, then a debounce counter (width ceil(log2(DEB_CYCLES))).
  - The counter resets whenever the synchronized level equals the debounced level, and increments otherwise.
  - On reaching DEB_CYCLES-1, the debounced level toggles and the counter clears.
  - A bounce shorter than DEB_CYCLES never changes the debounced level.
- Rising edge of a debounced level produces a one-cycle internal event.
- Latency for a clean press: the event occurs DEB_CYCLES+3 clk edges after the first edge that samples the raw high level.
- Field select:
  - config_en rising (registered) sets contadoresH=1. config_en low forces contadoresH=0.
  - Right event: contadoresH+1, wrapping NUM_FIELDS→1. Left event: contadoresH-1, wrapping 1→NUM_FIELDS.
  - Left and right events in the same cycle: no change.
  - Left/right while config_en=0: ignored.
  - The field update appears on contadoresH the cycle after the event.
- Step FSM states: IDLE, BLOCK, WAIT_FIRST, REPEAT.
  - IDLE to WAIT_FIRST: up XOR down debounced-level event. Emit one pulse on the matching output, load the repeat counter with REP_DELAY-1, latch the direction.
  - IDLE to BLOCK: up and down events in the same cycle, or both levels high. No pulse.
  - WAIT_FIRST to REPEAT: counter reaches 0 while the latched button is still held. Emit a pulse, reload REP_PERIOD-1.
  - REPEAT: every expiry emits a pulse and reloads.
  - Any state to IDLE: latched button released (debounced). No pulse.
  - Any state to BLOCK: the other direction button becomes pressed.
  - BLOCK to IDLE: both released.
  - Any state to IDLE, counter cleared: contadoresH changes, or config_en=0.
- Gating: Arriba/Abajo are registered and asserted only when config_en=1 and contadoresH!=0. They are never both high in the same cycle.
- Pulse timing: the output pulse is high the cycle after the event or counter expiry.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: the FSM behaves as above, with WAIT_FIRST/REPEAT auto-repeat.
- Undefined: WAIT_FIRST and REPEAT are not built and the repeat counter is removed. Exactly one pulse per debounced press; the FSM returns to IDLE on release.
- BLOCK behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - field code constants: CAMPO_NINGUNO=0, CAMPO_HORA=1, CAMPO_MIN=2, CAMPO_DIA=3, CAMPO_ANHO=4;
  - step FSM state encoding (2 bits);
  - default DEB_CYCLES, REP_DELAY, REP_PERIOD values.
- One sub-module, antirrebote: synchronizer plus debounce counter.
  - Parameter: DEB_CYCLES.
  - Ports: clk, reset, raw in, level out, rise out.
  - Instantiated four times.

Test Plan (bench overrides DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8):
1. Reset and mode entry: reset=0 then 1, config_en=1 → contadoresH 0 then 1 the cycle after registered config_en rises; Arriba=Abajo=0 throughout.
2. Field wrap: five clean btn_right presses from field 1 → contadoresH 2,3,4,5,1. One btn_left from 1 → 5. Left and right pressed on the same edge → no change.
3. Debounce: btn_up glitches of 1–3 cycles → no Arriba. A clean hold → exactly one Arriba at DEB_CYCLES+3=7 edges after the press, one cycle wide.
4. Auto-repeat with AUTO_REPEAT_EN, btn_up held 60 cycles:
   - Arriba at the press pulse (t0), then t0+20, t0+28, t0+36, t0+44, …
   - Release → no further pulses.
   - Without the macro → a single pulse only.
5. Conflict: hold btn_down, then press btn_up mid-repeat → Abajo stops, no Arriba; after both are released, a fresh btn_up press → one Arriba.
6. Gating and reset mid-hold:
   - config_en=0 while btn_up is held → Arriba never asserts and contadoresH=0.
   - Assert reset during REPEAT → outputs 0 immediately. After release with the button still held → one new pulse after the debounce delay.
